regfile_mp: RTL and testbench

//   Parametrised multi-read-port register file for the RV32 datapath; next generation of the 2R/1W regfile.

---
 rtl/regfile_mp.sv | 118 +++++++++++
 tb/tb_regfile_mp.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// Parametrised register file with NREAD registered read ports, one write port and a post-reset clear sweep.
// Define REGFILE_BYPASS_EN for write-first same-cycle read/write behaviour; otherwise reads are read-first.
module regfile_mp #(
  parameter  int XLEN     = 32,
  parameter  int DEPTH    = 32,
  parameter  int NREAD    = 2,
  parameter  int ZERO_REG = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  ready,
  input  logic [NREAD-1:0]      rd_en,
  input  logic [NREAD*AW-1:0]   raddr,
  output logic [NREAD*XLEN-1:0] rdata,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [XLEN-1:0]       wdata
);

  typedef enum logic {
    CLEAR,
    READY
  } stateT;

  // One extra bit so DEPTH itself is representable when DEPTH is a power of two.
  localparam logic [AW:0]   DEPTH_LIM = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX  = AW'(DEPTH - 1);

  stateT          state;
  stateT          nextState;
  logic [AW-1:0]  clrIdx;
  logic [AW-1:0]  nextClrIdx;
  logic           clearing;
  logic           writeValid;
  logic [AW-1:0]  rAddr   [NREAD];
  logic [XLEN-1:0] readVal [NREAD];
  logic [XLEN-1:0] mem    [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= CLEAR;
      clrIdx <= '0;
    end else begin
      state  <= nextState;
      clrIdx <= nextClrIdx;
    end
  end

  always_comb begin
    nextState  = state;
    nextClrIdx = clrIdx;
    clearing   = 1'b0;
    case (state)
      CLEAR: begin
        clearing = 1'b1;
        if (clrIdx == LAST_IDX) begin
          nextState = READY;
        end else begin
          nextClrIdx = clrIdx + 1'b1;
        end
      end
      READY: begin
        nextState = READY;
      end
    endcase
  end

  assign ready = (state == READY);

  // A write is real only once ready, in range, and not aimed at a hardwired x0.
  always_comb begin
    writeValid = (state == READY) && we && ({1'b0, waddr} < DEPTH_LIM);
    if ((ZERO_REG != 0) && (waddr == '0)) begin
      writeValid = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (clearing) begin
      mem[clrIdx] <= '0;
    end else if (writeValid) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar g = 0; g < NREAD; g++) begin : gAddr
    assign rAddr[g] = raddr[g*AW +: AW];
  end

  // x0 and out-of-range reads resolve to zero before any bypass is considered.
  always_comb begin
    for (int p = 0; p < NREAD; p++) begin
      readVal[p] = '0;
      if (({1'b0, rAddr[p]} < DEPTH_LIM) && !((ZERO_REG != 0) && (rAddr[p] == '0))) begin
        readVal[p] = mem[rAddr[p]];
`ifdef REGFILE_BYPASS_EN
        if (writeValid && (waddr == rAddr[p])) begin
          readVal[p] = wdata;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (state == READY) begin
      for (int p = 0; p < NREAD; p++) begin
        if (rd_en[p]) begin
          rdata[p*XLEN +: XLEN] <= readVal[p];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: a 32x2 instance with x0 hardwired and a 24x3 instance with an ordinary x0.
// Expected data comes from an array model of the register-file rules; bypass expectations follow REGFILE_BYPASS_EN.
module tb_regfile_mp;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;

  logic        weA;
  logic [4:0]  waddrA;
  logic [31:0] wdataA;
  logic [1:0]  rdEnA;
  logic [9:0]  raddrA;
  logic [63:0] rdataA;
  logic        readyA;

  logic        weB;
  logic [4:0]  waddrB;
  logic [31:0] wdataB;
  logic [2:0]  rdEnB;
  logic [14:0] raddrB;
  logic [95:0] rdataB;
  logic        readyB;

  logic [31:0] memA [32];
  logic [31:0] memB [24];
  logic [63:0] expA;
  logic [95:0] expB;
  logic [63:0] holdA;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(32), .DEPTH(32), .NREAD(2), .ZERO_REG(1)) dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .ready (readyA),
    .rd_en (rdEnA),
    .raddr (raddrA),
    .rdata (rdataA),
    .we    (weA),
    .waddr (waddrA),
    .wdata (wdataA)
  );

  regfile_mp #(.XLEN(32), .DEPTH(24), .NREAD(3), .ZERO_REG(0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .ready (readyB),
    .rd_en (rdEnB),
    .raddr (raddrB),
    .rdata (rdataB),
    .we    (weB),
    .waddr (waddrB),
    .wdata (wdataB)
  );

  task automatic checkOutput(input string tag, input logic [95:0] observed, input logic [95:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
  endtask

  function automatic logic [31:0] refRead(input int depth, input bit zeroReg, input int addr,
                                          input bit wOk, input int wAddr, input logic [31:0] wData,
                                          input logic [31:0] stored);
    if (addr >= depth || (zeroReg && addr == 0)) return 32'h0;
    if (BYPASS && wOk && wAddr == addr) return wData;
    return stored;
  endfunction

  task automatic applyStimulus(input string tag);
    bit wOkA;
    bit wOkB;
    int a;
    wOkA = weA && (int'(waddrA) < 32) && (waddrA != 5'd0);
    for (int p = 0; p < 2; p++) begin
      if (rdEnA[p]) begin
        a = int'(raddrA[p*5 +: 5]);
        expA[p*32 +: 32] = refRead(32, 1'b1, a, wOkA, int'(waddrA), wdataA, memA[a]);
      end
    end
    if (wOkA) memA[waddrA] = wdataA;
    wOkB = weB && (int'(waddrB) < 24);
    for (int p = 0; p < 3; p++) begin
      if (rdEnB[p]) begin
        a = int'(raddrB[p*5 +: 5]);
        expB[p*32 +: 32] = refRead(24, 1'b0, a, wOkB, int'(waddrB), wdataB, memB[(a < 24) ? a : 0]);
      end
    end
    if (wOkB) memB[waddrB] = wdataB;
    @(posedge clk);
    #1;
    checkOutput({tag, ":A"}, {32'h0, rdataA}, {32'h0, expA});
    checkOutput({tag, ":B"}, rdataB, expB);
  endtask

  task automatic setIdle();
    weA = 1'b0; waddrA = '0; wdataA = '0; rdEnA = '0; raddrA = '0;
    weB = 1'b0; waddrB = '0; wdataB = '0; rdEnB = '0; raddrB = '0;
  endtask

  // Releases reset with writes and reads requested; both must be ignored until ready.
  task automatic clearSweep(input string tag);
    weA = 1'b1; waddrA = 5'd3; wdataA = 32'hAAAA5555; rdEnA = 2'b11; raddrA = {5'd3, 5'd3};
    weB = 1'b1; waddrB = 5'd3; wdataB = 32'h5555AAAA; rdEnB = 3'b111; raddrB = {5'd3, 5'd3, 5'd3};
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 1; i <= 32; i++) begin
      @(posedge clk);
      #1;
      checkOutput({tag, ":readyA"}, {95'h0, readyA}, {95'h0, (i == 32)});
      checkOutput({tag, ":readyB"}, {95'h0, readyB}, {95'h0, (i >= 24)});
      checkOutput({tag, ":rdataA"}, {32'h0, rdataA}, 96'h0);
      checkOutput({tag, ":rdataB"}, rdataB, 96'h0);
      if (i == 24) begin
        weB = 1'b0;
        rdEnB = '0;
      end
    end
    foreach (memA[i]) memA[i] = '0;
    foreach (memB[i]) memB[i] = '0;
    expA = '0;
    expB = '0;
    setIdle();
  endtask

  initial begin
    rst_n = 1'b0;
    setIdle();
    expA = '0;
    expB = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rstReadyA", {95'h0, readyA}, 96'h0);
    checkOutput("rstRdataA", {32'h0, rdataA}, 96'h0);
    checkOutput("rstRdataB", rdataB, 96'h0);
    clearSweep("clear1");

    for (int a = 0; a < 32; a++) begin
      rdEnA = 2'b11; raddrA = {5'(a), 5'(a)};
      rdEnB = 3'b111; raddrB = {5'(a), 5'(a), 5'(a)};
      applyStimulus("zeroAfterClear");
      checkOutput("zeroAfterClearA", {32'h0, rdataA}, 96'h0);
    end
    setIdle();

    $display("[TB] write then read x5 on both ports");
    weA = 1'b1; waddrA = 5'd5; wdataA = 32'hDEADBEEF;
    applyStimulus("wrX5");
    weA = 1'b0; rdEnA = 2'b11; raddrA = {5'd5, 5'd5};
    applyStimulus("rdX5");
    checkOutput("x5p0", {64'h0, rdataA[31:0]}, {64'h0, 32'hDEADBEEF});
    checkOutput("x5p1", {64'h0, rdataA[63:32]}, {64'h0, 32'hDEADBEEF});

    $display("[TB] x0 write: hardwired in A, ordinary in B");
    rdEnA = '0; weA = 1'b1; waddrA = 5'd0; wdataA = 32'hFFFFFFFF;
    weB = 1'b1; waddrB = 5'd0; wdataB = 32'hFFFFFFFF;
    applyStimulus("wrX0");
    weA = 1'b0; weB = 1'b0; rdEnA = 2'b01; raddrA = '0; rdEnB = 3'b001; raddrB = '0;
    applyStimulus("rdX0");
    checkOutput("x0A", {64'h0, rdataA[31:0]}, 96'h0);
    checkOutput("x0B", {64'h0, rdataB[31:0]}, {64'h0, 32'hFFFFFFFF});
    setIdle();

    $display("[TB] same-cycle write and read of x7");
    weA = 1'b1; waddrA = 5'd7; wdataA = 32'h11;
    applyStimulus("wrX7");
    wdataA = 32'h22; rdEnA = 2'b01; raddrA = {5'd0, 5'd7};
    applyStimulus("collide");
    checkOutput("collideX7", {64'h0, rdataA[31:0]}, {64'h0, (BYPASS ? 32'h22 : 32'h11)});
    weA = 1'b0;
    applyStimulus("afterCollide");
    checkOutput("afterCollideX7", {64'h0, rdataA[31:0]}, {64'h0, 32'h22});

    $display("[TB] read hold with rd_en low");
    rdEnA = 2'b11; raddrA = {5'd7, 5'd5};
    applyStimulus("holdPrime");
    holdA = rdataA;
    rdEnA = '0;
    for (int i = 0; i < 4; i++) begin
      raddrA = 10'($urandom);
      weA = 1'b1; waddrA = (i % 2 == 0) ? 5'd5 : 5'd7; wdataA = $urandom;
      applyStimulus("hold");
      checkOutput("holdA", {32'h0, rdataA}, {32'h0, holdA});
    end
    setIdle();

    $display("[TB] depth-24 instance: out-of-range and three ports");
    weB = 1'b1; waddrB = 5'd30; wdataB = 32'h55555555;
    applyStimulus("wrOor");
    for (int r = 1; r <= 3; r++) begin
      waddrB = 5'(r); wdataB = 32'(r);
      applyStimulus("wrX123");
    end
    weB = 1'b0; rdEnB = 3'b111; raddrB = {5'd3, 5'd2, 5'd1};
    applyStimulus("rd3Ports");
    checkOutput("threePorts", rdataB, {32'd3, 32'd2, 32'd1});
    raddrB = {5'd30, 5'd6, 5'd30};
    applyStimulus("rdOor");
    checkOutput("oorB", rdataB, 96'h0);
    setIdle();

    $display("[TB] random traffic");
    for (int n = 0; n < 300; n++) begin
      weA = 1'($urandom); waddrA = 5'($urandom); wdataA = $urandom;
      rdEnA = 2'($urandom); raddrA = 10'($urandom);
      if ($urandom_range(0, 3) == 0) raddrA[4:0] = waddrA;
      weB = 1'($urandom); waddrB = 5'($urandom); wdataB = $urandom;
      rdEnB = 3'($urandom); raddrB = 15'($urandom);
      if ($urandom_range(0, 3) == 0) raddrB[9:5] = waddrB;
      applyStimulus("rand");
    end
    setIdle();

    $display("[TB] async reset from ready and mid-sweep");
    rst_n = 1'b0;
    #1;
    checkOutput("asyncRdataA", {32'h0, rdataA}, 96'h0);
    checkOutput("asyncRdataB", rdataB, 96'h0);
    checkOutput("asyncReadyA", {95'h0, readyA}, 96'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("midReadyA", {95'h0, readyA}, 96'h0);
    rst_n = 1'b0;
    #1;
    checkOutput("midRdataA", {32'h0, rdataA}, 96'h0);
    @(posedge clk);
    clearSweep("clear2");

    for (int a = 0; a < 32; a++) begin
      rdEnA = 2'b11; raddrA = {5'(a), 5'(a)};
      rdEnB = 3'b111; raddrB = {5'(a), 5'(a), 5'(a)};
      applyStimulus("zeroAfterReclear");
    end
    setIdle();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
